// File: rtl/fmsg_rx.sv
// rtl/fmsg_rx.sv - serial fmsg byte receiver with even parity, stop check and one-deep holding register
module fmsg_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] fmsg,
    output logic       fmsg_valid,
    input  logic       fmsg_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_overrun
);
    localparam logic [9:0] LAST_CNT = 10'(CLKS_PER_BIT - 1);
    localparam logic [9:0] HALF_CNT = 10'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t     state;
    logic       sync1, rxs;
    logic [9:0] cnt;
    logic [2:0] idx;
    logic [7:0] shreg;
    logic       par;
    logic       stop_edge, good_frame;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rxs   <= sync1;
        end
    end

    // The stop-bit sample edge is where every frame outcome is decided.
    assign stop_edge  = (state == STOP) && (cnt == LAST_CNT);
    assign good_frame = stop_edge && rxs && !(^{shreg, par});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_CNT) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        shreg <= {shreg[6:0], rxs};
                        if (idx == 3'd7) state <= PARITY;
                        else             idx   <= idx + 3'd1;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                PARITY: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        par   <= rxs;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt        <= '0;
                        frame_err  <= !rxs;
                        parity_err <= rxs && (^{shreg, par});
                        state      <= rxs ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                BREAK: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fmsg       <= 8'h00;
            fmsg_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (good_frame && (!fmsg_valid || fmsg_ready)) begin
                fmsg       <= shreg;
                fmsg_valid <= 1'b1;
            end else if (fmsg_valid && fmsg_ready) begin
                fmsg_valid <= 1'b0;
            end
            // A set in the same cycle as a clear wins.
            if (good_frame && fmsg_valid && !fmsg_ready) overrun <= 1'b1;
            else if (clr_overrun)                        overrun <= 1'b0;
        end
    end
endmodule

// File: doc/fmsg_rx.md
FMSG_RX -- requirements
Module: fmsg_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, 16, clock cycles per serial bit period; legal range 4..1023, always even.
REQ-002 Port: clk  input  1  single clock for all state.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: rx_in  input  1  asynchronous serial line; idle level 1.
REQ-005 Port: fmsg  output  8  received fmsg byte: [7:6] TYPE, [5:4] DEST, [3:0] PAYLOAD; feeds the downstream fmsg decoder.
REQ-006 Port: fmsg_valid  output  1  fmsg holds an undelivered byte.
REQ-007 Port: fmsg_ready  input  1  consumer accepts fmsg this cycle.
REQ-008 Port: parity_err  output  1  one-cycle pulse: frame dropped, bad parity.
REQ-009 Port: frame_err  output  1  one-cycle pulse: frame dropped, stop bit 0.
REQ-010 Port: overrun  output  1  sticky: good frame dropped because the holding register was full.
REQ-011 Port: clr_overrun  input  1  synchronous clear of overrun.

Function
REQ-012 rx_in passes through a 2-flop synchronizer, reset value 1; all logic uses the synchronized value (rxs).
REQ-013 Frame format: start bit 0, 8 data bits MSB first (fmsg[7] first), even parity bit (total ones over data+parity is even), stop bit 1.
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP, BREAK; one bit counter (0..CLKS_PER_BIT-1) and one data-bit index (0..7).
REQ-015 IDLE: rxs==0 -> START, bit counter cleared.
REQ-016 START: at count CLKS_PER_BIT/2-1, rxs==0 -> DATA, counter cleared; rxs==1 -> IDLE (glitch rejected, no output).
REQ-017 DATA: sample rxs at count CLKS_PER_BIT-1 into shift register, clear counter; after 8th sample -> PARITY.
REQ-018 PARITY: sample at count CLKS_PER_BIT-1 -> STOP.
REQ-019 STOP: sample at count CLKS_PER_BIT-1; decision made at this cycle edge (the stop-sample edge), then: stop==1 -> IDLE; stop==0 -> BREAK.
REQ-020 BREAK: remain until rxs==1, then -> IDLE; no start detected while in BREAK.
REQ-021 Decision priority at stop sample: stop==0 -> frame_err pulse (parity_err not asserted even if parity also bad); else parity bad -> parity_err pulse; else good frame.
REQ-022 Good frame with fmsg_valid==0, or fmsg_valid==1 and fmsg_ready==1 same cycle: fmsg loaded, fmsg_valid 1 on next cycle.
REQ-023 Good frame with fmsg_valid==1 and fmsg_ready==0: frame dropped, fmsg unchanged, overrun set.
REQ-024 fmsg_valid&&fmsg_ready with no load -> fmsg_valid 0 next cycle; fmsg holds last value.
REQ-025 fmsg stable while fmsg_valid==1 and not accepted.
REQ-026 clr_overrun clears overrun; simultaneous set and clear -> overrun stays 1.
REQ-027 Latency: fmsg_valid rises 1 cycle after the stop-bit sample edge; line-to-sample delay includes 2 synchronizer cycles.
REQ-028 Errored frames never modify fmsg or fmsg_valid.

Reset
REQ-029 rst asynchronously forces: FSM IDLE, counters 0, synchronizer flops 1, fmsg 0x00, fmsg_valid 0, parity_err 0, frame_err 0, overrun 0.
REQ-030 rst asserted mid-frame abandons the frame; after release, the next falling edge is treated as a new start bit.

Verification (CLKS_PER_BIT=16)
REQ-031 Send 0x6F, parity 0, stop 1, fmsg_ready=1 -> fmsg=0x6F, one-cycle fmsg_valid, no error pulses.
REQ-032 Send 0xC1, parity 1, fmsg_ready=0 -> fmsg_valid held, fmsg=0xC1 until ready; then send 0x1A, parity 1, with ready=0 -> overrun=1, fmsg stays 0xC1; clr_overrun -> overrun=0.
REQ-033 Send 0x1A with parity 0 -> parity_err one-cycle pulse, fmsg_valid stays 0.
REQ-034 Send 0x6F with stop 0 held low 40 clocks, then a good 0xC1 frame -> frame_err pulse, FSM in BREAK until line high, then fmsg=0xC1 valid.
REQ-035 rx_in low for 4 clocks -> no output, FSM back to IDLE; rst pulsed during DATA of a frame -> no output, next full frame 0x6F received correctly.
